// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: result width, ROB tag width, source count and
// the source enumeration used by the CDB scheduler and its consumers.
package cdb_arbiter_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ROB_DEPTH_BITS = 4;
  localparam int CDB_NUM_SRC    = 3;

  typedef enum logic [1:0] {
    CDB_ALU    = 2'd0,
    CDB_LOAD   = 2'd1,
    CDB_MULDIV = 2'd2
  } cdb_src_e;

  typedef struct packed {
    logic                      valid;
    logic [ROB_DEPTH_BITS-1:0] tag;
    logic [DATA_WIDTH-1:0]     data;
  } cdb_slot_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr,
// ascending with wrap. Reusable for any shared port.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_grant
);

  localparam int IW = $clog2(N);

  always_comb begin
    logic [IW-1:0] w_idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IW'((int'(ptr) + k) % N);
      if (!any_grant && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
        any_grant    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus scheduler: one holding slot per functional unit, a
// round-robin grant per cycle, and a registered broadcast to ROB/RS.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = CDB_NUM_SRC,
  parameter int TAG_W      = ROB_DEPTH_BITS,
  parameter int DATA_WIDTH = cdb_arbiter_pkg::DATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [NUM_SRC-1:0]                   src_valid,
  input  logic [NUM_SRC-1:0][TAG_W-1:0]        src_tag,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   src_data,
  output logic [NUM_SRC-1:0]                   src_ready,
  output logic                                 cdb_valid,
  output logic [TAG_W-1:0]                     cdb_tag,
  output logic [DATA_WIDTH-1:0]                cdb_data,
  output logic [$clog2(NUM_SRC)-1:0]           cdb_src
);

  localparam int IDX_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]                 r_slot_vld_p0;
  logic [NUM_SRC-1:0][TAG_W-1:0]      r_slot_tag_p0;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] r_slot_data_p0;
  logic [IDX_W-1:0]                   r_rr_ptr;

  logic                               r_cdb_vld_p1;
  logic [TAG_W-1:0]                   r_cdb_tag_p1;
  logic [DATA_WIDTH-1:0]              r_cdb_data_p1;
  logic [IDX_W-1:0]                   r_cdb_src_p1;

  logic [NUM_SRC-1:0]                 w_grant;
  logic [IDX_W-1:0]                   w_grant_idx;
  logic                               w_any_grant;
  logic [NUM_SRC-1:0]                 w_ready;
  logic [NUM_SRC-1:0]                 w_accept;
  logic [IDX_W-1:0]                   w_ptr_next;

  rr_arbiter #(
    .N (NUM_SRC)
  ) u_rr (
    .req       (r_slot_vld_p0),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any_grant (w_any_grant)
  );

  // A slot draining this cycle can be refilled at the same edge.
  assign w_ready    = (rst || flush) ? '0 : (~r_slot_vld_p0 | w_grant);
  assign w_accept   = src_valid & w_ready;
  assign w_ptr_next = (w_grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : w_grant_idx + 1'b1;

  // Stage p0: holding slots (payload needs no reset, validity does)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_accept[i]) begin
        r_slot_tag_p0[i]  <= src_tag[i];
        r_slot_data_p0[i] <= src_data[i];
      end
    end
  end

  // Stage p1: slot bookkeeping, pointer and broadcast register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_vld_p0 <= '0;
      r_rr_ptr      <= '0;
      r_cdb_vld_p1  <= 1'b0;
      r_cdb_tag_p1  <= '0;
      r_cdb_data_p1 <= '0;
      r_cdb_src_p1  <= '0;
    end else if (flush) begin
      r_slot_vld_p0 <= '0;
      r_rr_ptr      <= '0;
      r_cdb_vld_p1  <= 1'b0;
    end else begin
      r_slot_vld_p0 <= (r_slot_vld_p0 & ~w_grant) | w_accept;
      r_cdb_vld_p1  <= w_any_grant;
      if (w_any_grant) begin
        r_rr_ptr      <= w_ptr_next;
        r_cdb_tag_p1  <= r_slot_tag_p0[w_grant_idx];
        r_cdb_data_p1 <= r_slot_data_p0[w_grant_idx];
        r_cdb_src_p1  <= w_grant_idx;
      end
    end
  end

  assign src_ready = w_ready;
  assign cdb_valid = r_cdb_vld_p1;
  assign cdb_tag   = r_cdb_tag_p1;
  assign cdb_data  = r_cdb_data_p1;
  assign cdb_src   = r_cdb_src_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table, directed corner sequences and
// randomized traffic checked against a cycle-level scoreboard model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NS = CDB_NUM_SRC;
  localparam int TW = ROB_DEPTH_BITS;
  localparam int DW = DATA_WIDTH;
  localparam int SW = $clog2(NS);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [NS-1:0]          src_valid;
  logic [NS-1:0][TW-1:0]  src_tag;
  logic [NS-1:0][DW-1:0]  src_data;
  logic [NS-1:0]          src_ready;
  logic                   cdb_valid;
  logic [TW-1:0]          cdb_tag;
  logic [DW-1:0]          cdb_data;
  logic [SW-1:0]          cdb_src;

  int n_chk  = 0;
  int n_fail = 0;

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_ready (src_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", n_chk);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  bit [NS-1:0]   m_v;
  logic [TW-1:0] m_tag [NS];
  logic [DW-1:0] m_data[NS];
  int            m_ptr;
  bit            mc_v;
  logic [TW-1:0] mc_tag;
  logic [DW-1:0] mc_data;
  int            mc_src;
  bit            model_on = 0;

  function automatic int model_grant();
    for (int k = 0; k < NS; k++) begin
      int j = (m_ptr + k) % NS;
      if (m_v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [NS-1:0] model_ready();
    logic [NS-1:0] r;
    int g = model_grant();
    for (int i = 0; i < NS; i++)
      r[i] = !rst && !flush && (!m_v[i] || g == i);
    return r;
  endfunction

  task automatic model_step();
    int g;
    logic [NS-1:0] rdy;
    g   = model_grant();
    rdy = model_ready();
    if (rst) begin
      m_v = '0; m_ptr = 0; mc_v = 0; mc_tag = '0; mc_data = '0; mc_src = 0;
    end else if (flush) begin
      m_v = '0; m_ptr = 0; mc_v = 0;
    end else begin
      mc_v = (g >= 0);
      if (g >= 0) begin
        mc_tag = m_tag[g]; mc_data = m_data[g]; mc_src = g;
        m_ptr = (g + 1) % NS;
        m_v[g] = 1'b0;
      end
      for (int i = 0; i < NS; i++) begin
        if (src_valid[i] && rdy[i]) begin
          m_v[i] = 1'b1; m_tag[i] = src_tag[i]; m_data[i] = src_data[i];
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_check();
    chk("model_cdb_valid", 64'(cdb_valid), 64'(mc_v));
    chk("model_cdb_tag",   64'(cdb_tag),   64'(mc_tag));
    chk("model_cdb_data",  64'(cdb_data),  64'(mc_data));
    chk("model_cdb_src",   64'(cdb_src),   64'(mc_src));
    chk("model_src_ready", 64'(src_ready), 64'(model_ready()));
  endtask

  task automatic at_negedge();
    @(negedge clk);
    if (model_on) model_check();
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk);
    #1;
    model_on = 1;
  endtask

  function automatic logic [DW-1:0] data_of(input int s, input logic [TW-1:0] t);
    return DW'(s * 16 + int'(t)) * 32'h0101_0101;
  endfunction

  task automatic drive(input logic [NS-1:0] v, input logic [TW-1:0] t0,
                       input logic [TW-1:0] t1, input logic [TW-1:0] t2);
    src_valid   = v;
    src_tag[0]  = t0; src_tag[1]  = t1; src_tag[2]  = t2;
    src_data[0] = data_of(0, t0);
    src_data[1] = data_of(1, t1);
    src_data[2] = data_of(2, t2);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; drive('0, '0, '0, '0);
    at_negedge();
    finish_cycle();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            rst;
    logic [NS-1:0] vld;
    logic [TW-1:0] t0, t1, t2;
    logic [NS-1:0] e_ready;
    bit            e_cv;
    logic [TW-1:0] e_tag;
    int            e_src;
  } vec_t;

  vec_t tbl[14];

  initial begin
    bit found;
    // round robin with all three sources busy, then reset, then back-to-back on 0
    tbl[0]  = '{0, 3'b111, 1, 2, 3, 3'b111, 0, 0, 0};
    tbl[1]  = '{0, 3'b111, 1, 2, 3, 3'b001, 0, 0, 0};
    tbl[2]  = '{0, 3'b111, 1, 2, 3, 3'b010, 1, 1, 0};
    tbl[3]  = '{0, 3'b111, 1, 2, 3, 3'b100, 1, 2, 1};
    tbl[4]  = '{0, 3'b111, 1, 2, 3, 3'b001, 1, 3, 2};
    tbl[5]  = '{0, 3'b111, 1, 2, 3, 3'b010, 1, 1, 0};
    tbl[6]  = '{0, 3'b111, 1, 2, 3, 3'b100, 1, 2, 1};
    tbl[7]  = '{1, 3'b000, 0, 0, 0, 3'b000, 1, 3, 2};
    tbl[8]  = '{0, 3'b001, 1, 0, 0, 3'b111, 0, 0, 0};
    tbl[9]  = '{0, 3'b001, 2, 0, 0, 3'b111, 0, 0, 0};
    tbl[10] = '{0, 3'b001, 3, 0, 0, 3'b111, 1, 1, 0};
    tbl[11] = '{0, 3'b000, 0, 0, 0, 3'b111, 1, 2, 0};
    tbl[12] = '{0, 3'b000, 0, 0, 0, 3'b111, 1, 3, 0};
    tbl[13] = '{0, 3'b000, 0, 0, 0, 3'b111, 0, 3, 0};

    // reset state
    rst = 1'b1; flush = 1'b0; drive('0, '0, '0, '0);
    at_negedge();
    finish_cycle();
    at_negedge();
    chk("reset_cdb_valid", 64'(cdb_valid), 0);
    chk("reset_cdb_tag",   64'(cdb_tag),   0);
    chk("reset_cdb_data",  64'(cdb_data),  0);
    chk("reset_cdb_src",   64'(cdb_src),   0);
    chk("reset_src_ready", 64'(src_ready), 0);
    finish_cycle();

    foreach (tbl[r]) begin
      rst = tbl[r].rst;
      drive(tbl[r].vld, tbl[r].t0, tbl[r].t1, tbl[r].t2);
      at_negedge();
      chk($sformatf("tbl%0d_ready", r),    64'(src_ready), 64'(tbl[r].e_ready));
      chk($sformatf("tbl%0d_cdb_valid", r), 64'(cdb_valid), 64'(tbl[r].e_cv));
      chk($sformatf("tbl%0d_cdb_tag", r),  64'(cdb_tag),   64'(tbl[r].e_tag));
      chk($sformatf("tbl%0d_cdb_src", r),  64'(cdb_src),   64'(tbl[r].e_src));
      chk($sformatf("tbl%0d_cdb_data", r), 64'(cdb_data),
          64'(data_of(tbl[r].e_src, tbl[r].e_tag)));
      finish_cycle();
    end
    rst = 1'b0;

    // single result 0xDEAD on source 0: broadcast two cycles after handshake
    do_reset();
    drive(3'b001, 5, 0, 0);
    src_data[0] = 32'h0000_DEAD;
    at_negedge();
    chk("single_ready_c0", 64'(src_ready[0]), 1);
    finish_cycle();
    drive('0, 0, 0, 0);
    at_negedge();
    chk("single_ready_c1", 64'(src_ready[0]), 1);
    chk("single_valid_c1", 64'(cdb_valid), 0);
    finish_cycle();
    at_negedge();
    chk("single_valid_c2", 64'(cdb_valid), 1);
    chk("single_tag_c2",   64'(cdb_tag),   5);
    chk("single_data_c2",  64'(cdb_data),  32'h0000_DEAD);
    chk("single_src_c2",   64'(cdb_src),   0);
    chk("single_ready_c2", 64'(src_ready[0]), 1);
    finish_cycle();

    // flush with slots 0 and 2 occupied while a broadcast is live
    do_reset();
    drive(3'b101, 4, 0, 6);
    at_negedge(); finish_cycle();
    drive(3'b101, 8, 0, 9);
    at_negedge(); finish_cycle();
    flush = 1'b1;
    at_negedge();
    chk("flush_ready_during", 64'(src_ready), 0);
    chk("flush_valid_before", 64'(cdb_valid), 1);
    chk("flush_tag_before",   64'(cdb_tag),   4);
    finish_cycle();
    flush = 1'b0;
    drive('0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      at_negedge();
      chk($sformatf("flush_quiet%0d", c), 64'(cdb_valid), 0);
      finish_cycle();
    end

    // source 1 saturating, source 2 posts tag 7 once: no starvation
    do_reset();
    found = 0;
    for (int c = 0; c < 8; c++) begin
      drive({(c == 1), 1'b1, 1'b0}, 0, TW'(8 + c), 7);
      at_negedge();
      if (c >= 2 && c <= 5 && cdb_valid && cdb_src == 2 && cdb_tag == 7) found = 1;
      finish_cycle();
    end
    chk("no_starvation_tag7", 64'(found), 1);

    // reset mid-stream, then a fresh source-2 request
    drive(3'b111, 1, 2, 3);
    for (int c = 0; c < 3; c++) begin at_negedge(); finish_cycle(); end
    rst = 1'b1;
    at_negedge();
    chk("midrst_ready", 64'(src_ready), 0);
    finish_cycle();
    rst = 1'b0;
    drive(3'b100, 0, 0, 10);
    at_negedge();
    chk("midrst_valid", 64'(cdb_valid), 0);
    chk("midrst_tag",   64'(cdb_tag),   0);
    chk("midrst_data",  64'(cdb_data),  0);
    chk("midrst_src",   64'(cdb_src),   0);
    finish_cycle();
    drive('0, 0, 0, 0);
    at_negedge();
    chk("midrst_h1_valid", 64'(cdb_valid), 0);
    finish_cycle();
    at_negedge();
    chk("midrst_h2_valid", 64'(cdb_valid), 1);
    chk("midrst_h2_src",   64'(cdb_src),   2);
    chk("midrst_h2_tag",   64'(cdb_tag),   10);
    finish_cycle();

    // randomized traffic with occasional flush and reset
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < NS; i++) begin
        src_valid[i] = ($urandom_range(0, 3) != 0);
        src_tag[i]   = TW'($urandom);
        src_data[i]  = DW'($urandom);
      end
      at_negedge();
      finish_cycle();
    end
    rst = 1'b0; flush = 1'b0;
    at_negedge();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
